// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Drains words from a show-ahead FIFO pop interface and packs RATIO of them
//   into one wide beat presented on a valid/ready output port. A flush pulse
//   closes a partially filled beat early so the tail of a burst is never
//   stranded. Unfilled lanes of a partial beat read as zero.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   fifo_pop_req  pop request to the FIFO (high while filling)
//   fifo_pop_ack  FIFO non-empty; a word is consumed when req & ack
//   fifo_data     FIFO head word, valid when fifo_pop_ack is high
//   flush         single-cycle pulse: emit the partial beat
//   out_valid     wide beat available
//   out_ready     downstream accepts the beat
//   out_data      packed beat, word k at bits [k*WIDTH +: WIDTH]
//   out_count     number of valid words in the beat (1..RATIO)
module fifo_word_packer #(
   parameter  int WIDTH = 32,
   parameter  int RATIO = 4,
   localparam int CNTWD = $clog2(RATIO + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   fifo_pop_req,
   input  logic                   fifo_pop_ack,
   input  logic [WIDTH-1:0]       fifo_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*RATIO-1:0] out_data,
   output logic [CNTWD-1:0]       out_count
);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [CNTWD-1:0]       lane_q, lane_d;
   logic [WIDTH*RATIO-1:0] data_q, data_d;
   logic [CNTWD-1:0]       cnt_q, cnt_d;
   logic                   pop;

   // Request is a function of state only; gating by reset keeps the FIFO
   // from losing a word in the reset cycle.
   assign fifo_pop_req = (state_q == FILL) && !reset;
   assign pop          = fifo_pop_req && fifo_pop_ack;

   assign out_valid = (state_q == HOLD);
   assign out_data  = data_q;
   assign out_count = cnt_q;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         FILL: begin
            if (pop) begin
               for (int k = 0; k < RATIO; k++) begin
                  if (lane_q == CNTWD'(k)) begin
                     data_d[k*WIDTH +: WIDTH] = fifo_data;
                  end
               end
               lane_d = lane_q + CNTWD'(1);
            end
            if (pop && (lane_q == CNTWD'(RATIO - 1))) begin
               cnt_d   = CNTWD'(RATIO);
               state_d = HOLD;
            end else if (flush && ((lane_q != '0) || pop)) begin
               // A word popping alongside the flush belongs to this beat.
               cnt_d   = lane_q + CNTWD'(pop);
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Clearing data here is what makes unfilled lanes of the next
            // partial beat read as zero.
            if (out_ready) begin
               state_d = FILL;
               data_d  = '0;
               cnt_d   = '0;
               lane_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         lane_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Bench for fifo_word_packer (WIDTH=32, RATIO=4). A queue stands in for the
//   FIFO; a reference packer builds expected beats as words are popped and a
//   scoreboard compares them when the DUT hands a beat over.
module tb_fifo_word_packer;
   localparam int W  = 32;
   localparam int R  = 4;
   localparam int CW = 3;
   localparam int DW = W * R;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pop_req;
   logic          pop_ack = 1'b0;
   logic [W-1:0]  fifo_data = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]  fifo_q[$];
   beat_t         exp_q[$];
   bit            m_hold = 1'b0;
   int            m_lane = 0;
   logic [DW-1:0] m_buf = '0;

   int            cyc = 0;
   int            n_beats = 0;
   int            hs_cyc = 0;
   logic [DW-1:0] last_data = '0;
   int            last_cnt = 0;
   logic [DW-1:0] held;
   int            nb;
   int            cyc0;

   fifo_word_packer #(.WIDTH(W), .RATIO(R)) dut (
      .clk         (clk),
      .reset       (reset),
      .fifo_pop_req(pop_req),
      .fifo_pop_ack(pop_ack),
      .fifo_data   (fifo_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic upd_fifo();
      pop_ack   = (fifo_q.size() != 0);
      fifo_data = pop_ack ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [W-1:0] w);
      fifo_q.push_back(w);
      upd_fifo();
   endtask

   // One clock: check outputs mid-cycle against the reference, advance the
   // reference to its post-edge state, then retire the popped FIFO word.
   task automatic tick();
      bit    exp_req;
      bit    did_pop;
      beat_t b;
      @(negedge clk);
      exp_req = !m_hold && !reset;
      check("pop_req", pop_req, exp_req);
      check("out_valid", out_valid, m_hold);
      if (out_valid && out_ready && !reset) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            b = exp_q.pop_front();
            check("beat_data", out_data, b.d);
            check("beat_cnt", out_count, b.c);
            check("cnt_range", (out_count >= 1 && out_count <= R), 1);
         end
         n_beats++;
         hs_cyc    = cyc;
         last_data = out_data;
         last_cnt  = out_count;
      end
      did_pop = exp_req && pop_ack;
      if (reset) begin
         m_hold = 1'b0;
         m_lane = 0;
         m_buf  = '0;
         exp_q.delete();
      end else if (m_hold) begin
         if (out_ready) m_hold = 1'b0;
      end else begin
         if (did_pop) begin
            m_buf[m_lane*W +: W] = fifo_q[0];
            m_lane++;
         end
         if (m_lane == R || (flush && m_lane > 0)) begin
            exp_q.push_back('{m_buf, m_lane});
            m_hold = 1'b1;
            m_lane = 0;
            m_buf  = '0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (did_pop) void'(fifo_q.pop_front());
      upd_fifo();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // Reset state
      @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_count", out_count, 0);
      check("rst_data", out_data, 0);
      check("rst_req", pop_req, 0);
      tick();
      reset = 1'b0;

      // 8 words -> two full beats, 10 cycles from first pop
      for (int i = 1; i <= 8; i++) push(W'(i));
      nb   = n_beats;
      cyc0 = cyc;
      ticks(10);
      check("burst_beats", n_beats - nb, 2);
      check("burst_latency", hs_cyc - cyc0, 9);
      check("burst_last", last_data, {32'h8, 32'h7, 32'h6, 32'h5});
      check("burst_cnt", last_cnt, 4);

      // Two words then flush
      push(32'hA);
      push(32'hB);
      ticks(2);
      flush = 1'b1; tick(); flush = 1'b0;
      tick();
      check("flush2_data", last_data, {64'h0, 32'hB, 32'hA});
      check("flush2_cnt", last_cnt, 2);
      nb = n_beats;
      flush = 1'b1; tick(); flush = 1'b0;
      ticks(3);
      check("empty_flush", n_beats, nb);

      // Flush coincident with the 3rd pop, then with the 4th pop
      push(32'h1A); push(32'h1B); push(32'hC);
      ticks(2);
      flush = 1'b1; tick(); flush = 1'b0;
      tick();
      check("flush3_cnt", last_cnt, 3);
      check("flush3_lane2", last_data[95:64], 32'hC);
      nb = n_beats;
      for (int i = 0; i < 4; i++) push(W'(32'h21 + i));
      ticks(3);
      flush = 1'b1; tick(); flush = 1'b0;
      ticks(3);
      check("flush4_beats", n_beats - nb, 1);
      check("flush4_cnt", last_cnt, 4);

      // Backpressure in HOLD
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(W'(32'h31 + i));
      ticks(5);
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_data", out_data, held);
         check("hold_fifo", fifo_q.size(), 4);
      end
      nb = n_beats;
      out_ready = 1'b1;
      ticks(10);
      check("release_beats", n_beats - nb, 2);
      check("release_fifo", fifo_q.size(), 0);

      // Reset with two lanes filled
      push(32'h41); push(32'h42); push(32'h43);
      ticks(2);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rstmid_valid", out_valid, 0);
      check("rstmid_count", out_count, 0);
      check("rstmid_fifo", fifo_q.size(), 1);
      push(32'h44); push(32'h45); push(32'h46);
      ticks(5);
      check("rstmid_fresh", last_data, {32'h46, 32'h45, 32'h44, 32'h43});

      // Reset while holding a beat
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(W'(32'h51 + i));
      ticks(5);
      check("rsthold_pre", out_valid, 1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rsthold_valid", out_valid, 0);
      check("rsthold_count", out_count, 0);
      check("rsthold_data", out_data, 0);
      out_ready = 1'b1;

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         if (fifo_q.size() < 6 && $urandom_range(1, 0) == 1) push($urandom);
         out_ready = ($urandom_range(3, 0) != 0);
         flush     = ($urandom_range(7, 0) == 0);
         tick();
      end
      flush     = 1'b0;
      out_ready = 1'b1;
      ticks(20);
      flush = 1'b1; tick(); flush = 1'b0;
      ticks(3);
      check("drain_fifo", fifo_q.size(), 0);
      check("drain_exp", exp_q.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
